// File: rtl/guess_engine.sv
// guess_engine -- sequencing controller for one round of Hangman.
//
// Latches the selected word and hint mask on load, reveals blanks and hinted
// letters with a six-cycle load scan, then accepts guesses over a valid/ready
// handshake. Each new letter is compared against the word one position per
// cycle. Misses are counted and the win/lost levels are raised.
//
// Build option: define REPEAT_PENALTY_EN to count a repeated letter as a miss.
// Without it, a repeat guess is accepted and produces no effect.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   load                    pulse: latch word/hint_mask, start a new round
//   word[29:0]              six 5-bit letter codes (31 = blank position)
//   hint_mask[25:0]         letters given as hints at load
//   guess_valid/ready       guess handshake; guess_letter sampled on accept
//   guess_letter[4:0]       guessed letter code (26..31 accepted, ignored)
//   revealed[5:0]           positions shown
//   guessed[25:0]           letters already used (guessed or hinted)
//   wrong_count[3:0]        misses so far
//   hit, miss               one-cycle result pulses
//   win_game, lost_game     round outcome levels
//   busy                    load scan, guess scan or result in progress
module guess_engine #(
  parameter int MAX_WRONG = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [29:0] word,
  input  logic [25:0] hint_mask,
  input  logic        guess_valid,
  output logic        guess_ready,
  input  logic [4:0]  guess_letter,
  output logic [5:0]  revealed,
  output logic [25:0] guessed,
  output logic [3:0]  wrong_count,
  output logic        hit,
  output logic        miss,
  output logic        win_game,
  output logic        lost_game,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LSCAN  = 3'd1,
    WAIT   = 3'd2,
    GSCAN  = 3'd3,
    RESULT = 3'd4,
    OVER   = 3'd5
  } state_t;

  localparam logic [3:0] MAX_WRONG_4 = 4'(MAX_WRONG);

  state_t      state;
  logic [2:0]  index;
  logic [29:0] word_reg;
  logic [25:0] hint_reg;
  logic [4:0]  letter_reg;
  logic        match_reg;

  // Per-position codes; slots 6 and 7 read as blank so a 3-bit index is safe.
  logic [4:0] codes [8];
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_codes
      assign codes[gi] = word_reg[5*gi +: 5];
    end
  endgenerate
  assign codes[6] = 5'd31;
  assign codes[7] = 5'd31;

  logic [4:0]  cur_code;
  logic [5:0]  pos_bit;
  logic [31:0] hint_ext;
  logic [31:0] guessed_ext;
  logic [31:0] letter_onehot;
  logic        lscan_show;
  logic [5:0]  rev_lscan;
  logic        gscan_eq;
  logic        match_now;
  logic [3:0]  wrong_next;

  always_comb begin
    cur_code      = codes[index];
    pos_bit       = 6'd1 << index;
    hint_ext      = {6'd0, hint_reg};
    guessed_ext   = {6'd0, guessed};
    letter_onehot = 32'd1 << guess_letter;
    // Code 31 is a blank; codes 26..30 are never shown by a hint.
    lscan_show    = (cur_code == 5'd31) ||
                    ((cur_code < 5'd26) && hint_ext[cur_code]);
    rev_lscan     = lscan_show ? (revealed | pos_bit) : revealed;
    gscan_eq      = (cur_code == letter_reg);
    match_now     = match_reg | gscan_eq;
    // The miss pulse is live during RESULT and drives the counter update.
    wrong_next    = (miss && (wrong_count < MAX_WRONG_4)) ? wrong_count + 4'd1
                                                          : wrong_count;
  end

  assign guess_ready = (state == WAIT);
  assign busy        = (state == LSCAN) || (state == GSCAN) || (state == RESULT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      index       <= 3'd0;
      word_reg    <= '0;
      hint_reg    <= '0;
      letter_reg  <= '0;
      match_reg   <= 1'b0;
      revealed    <= '0;
      guessed     <= '0;
      wrong_count <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      win_game    <= 1'b0;
      lost_game   <= 1'b0;
    end else if (load) begin
      // Load overrides everything, including an in-flight guess scan, so a
      // partially scanned guess never commits.
      state       <= LSCAN;
      index       <= 3'd0;
      word_reg    <= word;
      hint_reg    <= hint_mask;
      match_reg   <= 1'b0;
      revealed    <= '0;
      guessed     <= hint_mask;
      wrong_count <= '0;
      hit         <= 1'b0;
      miss        <= 1'b0;
      win_game    <= 1'b0;
      lost_game   <= 1'b0;
    end else begin
      hit  <= 1'b0;
      miss <= 1'b0;
      case (state)
        LSCAN: begin
          revealed <= rev_lscan;
          if (index == 3'd5) begin
            win_game <= &rev_lscan;
            state    <= (&rev_lscan) ? OVER : WAIT;
          end else begin
            index <= index + 3'd1;
          end
        end
        WAIT: begin
          if (guess_valid) begin
            if (guess_letter > 5'd25) begin
              state <= RESULT;
            end else if (guessed_ext[guess_letter]) begin
              state <= RESULT;
`ifdef REPEAT_PENALTY_EN
              miss  <= 1'b1;
`endif
            end else begin
              guessed    <= guessed | letter_onehot[25:0];
              letter_reg <= guess_letter;
              match_reg  <= 1'b0;
              index      <= 3'd0;
              state      <= GSCAN;
            end
          end
        end
        GSCAN: begin
          if (gscan_eq) begin
            revealed <= revealed | pos_bit;
          end
          match_reg <= match_now;
          if (index == 3'd5) begin
            hit   <= match_now;
            miss  <= ~match_now;
            state <= RESULT;
          end else begin
            index <= index + 3'd1;
          end
        end
        RESULT: begin
          wrong_count <= wrong_next;
          if (&revealed) begin
            win_game <= 1'b1;
            state    <= OVER;
          end else if (wrong_next == MAX_WRONG_4) begin
            lost_game <= 1'b1;
            state     <= OVER;
          end else begin
            state <= WAIT;
          end
        end
        IDLE:    state <= IDLE;
        OVER:    state <= OVER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/guess_engine.md
# guess_engine

Sequencing controller for one round of Hangman. It latches the selected word and its hint mask from level selection and scans the word letter by letter. It accepts player guesses over a valid/ready handshake, updates the revealed-position and guessed-letter sets, counts misses, and raises the win/lost levels that drive the game state machine.

## Interface

Parameters:
- MAX_WRONG, default 6: miss count at which the round is lost (1..15).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- load  in  1  one-cycle pulse; latch word/hint_mask and start a new round.
- word  in  30  six 5-bit letter codes; position p = word[5p+4:5p]; 0..25 = a..z, 31 = blank (unused position).
- hint_mask  in  26  bit i set: letter i is given as a hint at load.
- guess_valid  in  1  guess_letter is offered.
- guess_ready  out  1  engine can accept a guess.
- guess_letter  in  5  guessed letter code.
- revealed  out  6  bit p set: position p is shown.
- guessed  out  26  bit i set: letter i already used (guessed or hinted).
- wrong_count  out  4  misses so far.
- hit  out  1  one-cycle pulse: the last guess revealed at least one position.
- miss  out  1  one-cycle pulse: the last guess counted as wrong.
- win_game  out  1  level; all positions revealed.
- lost_game  out  1  level; wrong_count reached MAX_WRONG.
- busy  out  1  a load or guess scan is in progress.

## Operation

States:
- IDLE
- LSCAN (load scan, index 0..5)
- WAIT
- GSCAN (guess scan, index 0..5)
- RESULT
- OVER

Reset:
- State goes to IDLE.
- Every output is 0, including guess_ready.

Load:
- load is honoured in every state, including mid-scan, and has priority over any guess in the same cycle.
- The engine latches word and hint_mask and clears revealed, wrong_count, win_game, lost_game, hit and miss.
- guessed is set to hint_mask.
- The engine enters LSCAN.

LSCAN:
- Processes one position per cycle.
- A position is revealed if its code is 31 or if hint_mask[code] is set.
- After index 5, the engine goes to WAIT, or to OVER with win_game=1 if revealed is all ones.

WAIT:
- guess_ready=1.
- A guess is accepted on a cycle where guess_valid and guess_ready are both high.
- A letter with code 26..31 is accepted and discarded: the engine goes to RESULT with neither hit nor miss.
- A repeat letter (guessed bit already set) goes straight to RESULT; its handling is given in Configuration.
- A new letter sets its guessed bit and enters GSCAN.

GSCAN:
- Compares position `index` with the latched letter and sets the revealed bit on a match.
- A sticky match flag collects the result over the 6 cycles.

RESULT (1 cycle):
- If the match flag is set, hit=1.
- Otherwise miss=1 and wrong_count increments; wrong_count saturates at MAX_WRONG.
- If revealed is all ones, win_game is set at the same edge.
- Otherwise, if the new wrong_count equals MAX_WRONG, lost_game is set.
- Next state is OVER if win_game or lost_game was set, otherwise WAIT.
- win and lost are mutually exclusive, because a miss never reveals a position.

OVER:
- guess_ready=0.
- win_game or lost_game stays asserted until load or reset.

Outputs:
- guess_ready=0 in every state except WAIT.
- busy=1 in LSCAN, GSCAN and RESULT.
- Before the first load, no guess is ever accepted.

## Timing

Load:
- load at cycle L; LSCAN runs L+1..L+6.
- guess_ready=1, or win_game=1, from L+7.

New guess accepted at cycle T:
- GSCAN runs T+1..T+6.
- RESULT is cycle T+7: hit or miss high in T+7 only.
- wrong_count, win_game and lost_game take their new values from T+8.
- guess_ready is high again at T+8 if the round continues.

Repeat or invalid guess accepted at T:
- RESULT is cycle T+1.
- guess_ready is high again at T+2.

Other rules:
- Exactly one guess is accepted per handshake.
- guess_letter is sampled only on the accept cycle.
- Changes to word or hint_mask after load have no effect.
- load during GSCAN aborts the scan: the pending guess is dropped, no pulse is generated, and the old state is not partially committed.

## Configuration

- REPEAT_PENALTY_EN defined: a repeat guess produces miss=1 in RESULT, increments wrong_count, and can trigger lost_game.
- REPEAT_PENALTY_EN undefined: a repeat guess produces no hit, no miss and no counter change.
- An invalid code (26..31) is never penalised in either build.

## Test plan

- Load word "banana" (1,0,13,0,13,0), hint_mask=0, then guess 'a' (0) -> guess_ready at L+7; at T+7 hit=1; revealed=6'b101010 from T+8; wrong_count=0.
- Same round, guesses 'b' then 'n' -> after the second RESULT, revealed=6'b111111, win_game=1, guess_ready=0, and further guess_valid is ignored.
- Load "hat" (7,0,19, blanks 31,31,31), then 6 distinct wrong letters with MAX_WRONG=6 -> miss pulse on each; wrong_count steps 1..6; lost_game=1 after the 6th; win_game=0.
- Hint_mask with bit 0 set on "banana", then guess 'a' -> revealed=6'b101010 after LSCAN; guessed[0]=1; the guess takes the repeat path with RESULT at T+1: no pulse without REPEAT_PENALTY_EN, miss and wrong_count=1 with it.
- load asserted at T+3 of a guess scan -> no hit or miss pulse, all state cleared, new LSCAN from T+4, guess_ready at T+10.
- Reset asserted in OVER -> next cycle all outputs 0 and guess_valid is not accepted until a load.
